// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

  localparam int unsigned OvsDefault = 16;

  localparam logic [1:0] DataLen5 = 2'b00;
  localparam logic [1:0] DataLen6 = 2'b01;
  localparam logic [1:0] DataLen7 = 2'b10;
  localparam logic [1:0] DataLen8 = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } rx_state_e;

  // Bits enter at [7] and move down, so a short character sits in the top bits.
  function automatic logic [7:0] rjust(input logic [7:0] sr, input logic [1:0] len);
    return sr >> (2'd3 - len);
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Character/configuration bundle between the receive engine and the APB/FIFO side.
interface uart_rx_if;

  logic [1:0] data_len;
  logic       parity_en;
  logic       parity_odd;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       parity_err;
  logic       frame_err;
  logic       break_err;
  logic       rx_busy;

  modport master (
    input  data_len, parity_en, parity_odd,
    output rx_data, rx_valid, parity_err, frame_err, break_err, rx_busy
  );

  modport slave (
    output data_len, parity_en, parity_odd,
    input  rx_data, rx_valid, parity_err, frame_err, break_err, rx_busy
  );

endinterface

// File: rtl/uart_sync.sv
// N-flop synchroniser for idle-high asynchronous inputs (RXD, CTS, DSR).
module uart_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic pclk,
  input  logic presetn,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge pclk) begin
    if (!presetn) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx_core.sv
// UART receive engine: 16x oversampled start qualification, 5-8 data bits,
// optional parity and one stop bit, one character per frame with error flags.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int unsigned OVS         = OvsDefault,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic      pclk,
  input  logic      presetn,
  input  logic      rxd,
  input  logic      bclk_rx,
  output logic      rx_bclk_en,
  uart_rx_if.master rx_if
);

  localparam int unsigned TickW = $clog2(OVS);
  localparam logic [TickW-1:0] TickMid  = TickW'(OVS / 2 - 1);
  localparam logic [TickW-1:0] TickLast = TickW'(OVS - 1);

  logic rxd_s;

  uart_sync #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .pclk   (pclk),
    .presetn(presetn),
    .d      (rxd),
    .q      (rxd_s)
  );

  rx_state_e        state_q, state_d;
  logic [TickW-1:0] tick_q, tick_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic [1:0]       len_q, len_d;
  logic             pen_q, pen_d;
  logic             podd_q, podd_d;
  logic             par_bit_q, par_bit_d;
  logic             par_flag_q, par_flag_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             perr_q, perr_d;
  logic             ferr_q, ferr_d;
  logic             berr_q, berr_d;

  logic bit_tick;
  assign bit_tick = bclk_rx && (tick_q == TickLast);

  always_comb begin
    state_d    = state_q;
    tick_d     = tick_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    len_d      = len_q;
    pen_d      = pen_q;
    podd_d     = podd_q;
    par_bit_d  = par_bit_q;
    par_flag_d = par_flag_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    berr_d     = berr_q;

    // Modulo-OVS counting keeps every later sample exactly one bit apart.
    if (state_q != StIdle && bclk_rx) begin
      tick_d = tick_q + 1'b1;
    end

    case (state_q)
      StIdle: begin
        if (!rxd_s) begin
          state_d = StStart;
          tick_d  = '0;
          len_d   = rx_if.data_len;
          pen_d   = rx_if.parity_en;
          podd_d  = rx_if.parity_odd;
        end
      end
      StStart: begin
        if (bclk_rx && tick_q == TickMid) begin
          if (rxd_s) begin
            state_d = StIdle;
          end else begin
            state_d    = StData;
            tick_d     = '0;
            bit_d      = '0;
            shift_d    = '0;
            par_bit_d  = 1'b0;
            par_flag_d = 1'b0;
          end
        end
      end
      StData: begin
        if (bit_tick) begin
          shift_d = {rxd_s, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          // Last bit index is data_len + 4, i.e. {1, data_len}.
          if (bit_q == {1'b1, len_q}) begin
            state_d = pen_q ? StParity : StStop;
          end
        end
      end
      StParity: begin
        if (bit_tick) begin
          par_bit_d  = rxd_s;
          par_flag_d = rxd_s ^ (^shift_q) ^ podd_q;
          state_d    = StStop;
        end
      end
      StStop: begin
        if (bit_tick) begin
          state_d    = StIdle;
          rx_valid_d = 1'b1;
          rx_data_d  = rjust(shift_q, len_q);
          ferr_d     = ~rxd_s;
          perr_d     = par_flag_q;
          berr_d     = (shift_q == 8'h00) && !(pen_q && par_bit_q) && !rxd_s;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (!presetn) begin
      state_q    <= StIdle;
      tick_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      len_q      <= '0;
      pen_q      <= 1'b0;
      podd_q     <= 1'b0;
      par_bit_q  <= 1'b0;
      par_flag_q <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      berr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_q     <= tick_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      len_q      <= len_d;
      pen_q      <= pen_d;
      podd_q     <= podd_d;
      par_bit_q  <= par_bit_d;
      par_flag_q <= par_flag_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      berr_q     <= berr_d;
    end
  end

  assign rx_bclk_en       = (state_q != StIdle);
  assign rx_if.rx_busy    = (state_q != StIdle);
  assign rx_if.rx_data    = rx_data_q;
  assign rx_if.rx_valid   = rx_valid_q;
  assign rx_if.parity_err = perr_q;
  assign rx_if.frame_err  = ferr_q;
  assign rx_if.break_err  = berr_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Bench for uart_rx_core: directed frames plus random frames against a frame-level model.
module tb_uart_rx_core;
  import uart_pkg::*;

  localparam int BitClks = 32;

  logic pclk = 1'b0;
  logic presetn = 1'b0;
  logic rxd = 1'b1;
  logic bclk_rx = 1'b0;
  logic rx_bclk_en;

  uart_rx_if rx_if();

  uart_rx_core #(
    .OVS        (16),
    .SYNC_STAGES(2)
  ) dut (
    .pclk      (pclk),
    .presetn   (presetn),
    .rxd       (rxd),
    .bclk_rx   (bclk_rx),
    .rx_bclk_en(rx_bclk_en),
    .rx_if     (rx_if)
  );

  always #5 pclk = ~pclk;

  // Baud generator with div_val = 2: first tick one pclk after enable, then every 2 pclk.
  int div_cnt = 0;
  always @(posedge pclk) begin
    if (!rx_bclk_en) begin
      div_cnt <= 0;
      bclk_rx <= 1'b0;
    end else begin
      bclk_rx <= (div_cnt == 0);
      div_cnt <= (div_cnt + 1) % 2;
    end
  end

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
    logic       berr;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   n_valid = 0;
  bit   chk_en_next = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [7:0] data, input logic [1:0] len, input bit pe,
                                 input bit podd, input bit pbit, input bit stop);
    exp_t       e;
    int         n;
    logic [7:0] d;
    bit         want;
    n      = int'(len) + 5;
    d      = data & 8'((1 << n) - 1);
    want   = (($countones(d) % 2) == 1) ^ podd;
    e.data = d;
    e.perr = pe && (pbit != want);
    e.ferr = !stop;
    e.berr = (d == 8'h00) && !(pe && pbit) && !stop;
    return e;
  endfunction

  always @(negedge pclk) begin
    exp_t e;
    if (chk_en_next) begin
      check_eq("bclk_en_after_valid", rx_bclk_en, 0);
      chk_en_next = 1'b0;
    end
    if (rx_if.rx_valid) begin
      n_valid++;
      if (exp_q.size() == 0) begin
        check_eq("unexpected_valid", rx_if.rx_valid, 0);
      end else begin
        e = exp_q.pop_front();
        check_eq("rx_data", rx_if.rx_data, e.data);
        check_eq("parity_err", rx_if.parity_err, e.perr);
        check_eq("frame_err", rx_if.frame_err, e.ferr);
        check_eq("break_err", rx_if.break_err, e.berr);
        chk_en_next = !e.ferr;
      end
    end
  end

  // rst_at >= 0 pulses presetn mid-way through that frame bit and abandons the frame.
  task automatic send_frame(input logic [7:0] data, input logic [1:0] len, input bit pe,
                            input bit podd, input bit pbit, input bit stop, input int gap,
                            input int rst_at);
    bit bits[$];
    rx_if.data_len   = len;
    rx_if.parity_en  = pe;
    rx_if.parity_odd = podd;
    bits.push_back(1'b0);
    for (int i = 0; i < int'(len) + 5; i++) bits.push_back(data[i]);
    if (pe) bits.push_back(pbit);
    bits.push_back(stop);
    if (rst_at < 0) exp_q.push_back(model(data, len, pe, podd, pbit, stop));
    foreach (bits[i]) begin
      rxd = bits[i];
      for (int c = 0; c < BitClks; c++) begin
        @(negedge pclk);
        if (i == rst_at && c == BitClks / 2) begin
          presetn = 1'b0;
          @(negedge pclk);
          presetn = 1'b1;
          rxd = 1'b1;
          repeat (2 * BitClks) @(negedge pclk);
          return;
        end
      end
    end
    rxd = 1'b1;
    repeat (gap) @(negedge pclk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int         v0;
    logic [7:0] d;
    logic [1:0] len;
    bit         pe, podd, pbit, stop;

    rx_if.data_len   = DataLen8;
    rx_if.parity_en  = 1'b0;
    rx_if.parity_odd = 1'b0;
    repeat (4) @(negedge pclk);
    presetn = 1'b1;
    @(negedge pclk);
    check_eq("reset_rx_data", rx_if.rx_data, 0);
    check_eq("reset_rx_valid", rx_if.rx_valid, 0);
    check_eq("reset_errs", {rx_if.parity_err, rx_if.frame_err, rx_if.break_err}, 0);
    check_eq("reset_busy", rx_if.rx_busy, 0);
    check_eq("reset_bclk_en", rx_bclk_en, 0);

    // 8N1 0xA5
    v0 = n_valid;
    send_frame(8'hA5, DataLen8, 0, 0, 0, 1, 40, -1);
    check_eq("t1_valid_count", n_valid - v0, 1);

    // 7E1 0x35 with good and bad parity
    send_frame(8'h35, DataLen7, 1, 0, 0, 1, 40, -1);
    send_frame(8'h35, DataLen7, 1, 0, 1, 1, 40, -1);

    // Short low glitch must be rejected as a false start
    v0 = n_valid;
    rxd = 1'b0;
    repeat (5) @(negedge pclk);
    check_eq("glitch_start_seen", rx_if.rx_busy, 1);
    repeat (5) @(negedge pclk);
    rxd = 1'b1;
    repeat (10) @(negedge pclk);
    check_eq("glitch_bclk_en", rx_bclk_en, 0);
    check_eq("glitch_busy", rx_if.rx_busy, 0);
    repeat (40) @(negedge pclk);
    check_eq("glitch_no_valid", n_valid - v0, 0);

    // Framing error, then break
    send_frame(8'h5A, DataLen8, 0, 0, 0, 0, 48, -1);
    send_frame(8'h00, DataLen8, 0, 0, 0, 0, 48, -1);

    // Load non-zero outputs, then reset during data bit 3
    send_frame(8'hFF, DataLen8, 0, 0, 0, 0, 48, -1);
    v0 = n_valid;
    send_frame(8'hC3, DataLen8, 0, 0, 0, 1, 0, 4);
    check_eq("rst_no_valid", n_valid - v0, 0);
    check_eq("rst_rx_data", rx_if.rx_data, 0);
    check_eq("rst_errs", {rx_if.parity_err, rx_if.frame_err, rx_if.break_err}, 0);
    check_eq("rst_busy", rx_if.rx_busy, 0);
    send_frame(8'h3C, DataLen8, 0, 0, 0, 1, 40, -1);

    // Back-to-back 5N1 frames, no idle gap
    v0 = n_valid;
    send_frame(8'h1F, DataLen5, 0, 0, 0, 1, 0, -1);
    send_frame(8'h0A, DataLen5, 0, 0, 0, 1, 40, -1);
    check_eq("b2b_valid_count", n_valid - v0, 2);

    // Random frames
    for (int k = 0; k < 40; k++) begin
      d    = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      len  = 2'($urandom_range(0, 3));
      pe   = 1'($urandom_range(0, 1));
      podd = 1'($urandom_range(0, 1));
      pbit = 1'($urandom_range(0, 1));
      stop = ($urandom_range(0, 6) != 0);
      send_frame(d, len, pe, podd, pbit, stop,
                 stop ? int'($urandom_range(0, 20)) : int'($urandom_range(40, 70)), -1);
    end

    repeat (100) @(negedge pclk);
    check_eq("exp_pending", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
